// File: rtl/pe_pkg.sv
// Shared PE constants and the filter spad controller state type.
package pe_pkg;
  localparam int FILTER_SPAD_DEPTH = 224;
  localparam int FILTER_ADDR_W     = 8;
  localparam int DATA_W            = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_READ = 2'd2
  } spad_state_e;
endpackage

// File: rtl/filter_spad_ctrl_if.sv
// Filter load stream, MAC operand stream and spad port of the filter spad controller.
interface filter_spad_ctrl_if;
  import pe_pkg::*;

  logic [DATA_W-1:0]        in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [FILTER_ADDR_W-1:0] spad_addr;
  logic                     spad_we;
  logic [DATA_W-1:0]        spad_wdata;
  logic [DATA_W-1:0]        spad_rdata;

  modport master (
    input  in_data, in_valid, out_ready, spad_rdata,
    output in_ready, out_data, out_valid, spad_addr, spad_we, spad_wdata
  );

  modport slave (
    output in_data, in_valid, out_ready, spad_rdata,
    input  in_ready, out_data, out_valid, spad_addr, spad_we, spad_wdata
  );
endinterface

// File: rtl/filter_addr_gen.sv
// Base/stride/count address walker with modulo-DEPTH wrap; addr is the next address to issue.
// last is high while exactly one address remains.
module filter_addr_gen
  import pe_pkg::*;
#(
  parameter int DEPTH  = FILTER_SPAD_DEPTH,
  parameter int ADDR_W = FILTER_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  input  logic [ADDR_W-1:0] count,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              active,
  output logic              last
);
  logic [ADDR_W-1:0] left_q;
  logic [ADDR_W:0]   sum;
  logic [ADDR_W:0]   nxt;

  // base and stride are both below DEPTH, so one subtraction always suffices
  always_comb begin
    sum = {1'b0, addr} + {1'b0, stride};
    nxt = sum;
    if (sum >= (ADDR_W+1)'(DEPTH)) nxt = sum - (ADDR_W+1)'(DEPTH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr   <= '0;
      left_q <= '0;
    end else if (start) begin
      addr   <= base;
      left_q <= count;
    end else if (step && left_q != '0) begin
      addr   <= nxt[ADDR_W-1:0];
      left_q <= left_q - 1'b1;
    end
  end

  assign active = (left_q != '0);
  assign last   = (left_q == ADDR_W'(1));
endmodule

// File: rtl/filter_spad_ctrl.sv
// Owns the filter spad port: sequential loads from the filter FIFO and strided reads to the MAC.
// Optional FILTER_SPAD_CTRL_CHECKSUM_EN adds load_chk, the XOR of the words of the current load.
module filter_spad_ctrl #(
  parameter int DEPTH  = pe_pkg::FILTER_SPAD_DEPTH,
  parameter int ADDR_W = pe_pkg::FILTER_ADDR_W,
  parameter int DATA_W = pe_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_len,
  output logic              load_done,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W-1:0] rd_count,
  input  logic [ADDR_W-1:0] rd_stride,
  output logic              rd_done,
  output logic              busy,
`ifdef FILTER_SPAD_CTRL_CHECKSUM_EN
  output logic [DATA_W-1:0] load_chk,
`endif
  filter_spad_ctrl_if.master bus
);
  import pe_pkg::*;

  spad_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, ptr_q, addr_q, len_clamp, ag_addr;
  logic [DATA_W-1:0] wdata_q, out_data_q;
  logic              we_q, load_done_q, zero_rd_q, out_valid_q, final_q;
  logic              ag_active, ag_last;
  logic              idle, load_go, load_zero, rd_go, rd_zero;
  logic              in_xfer, load_end, issue, rd_hs, rd_last;

  assign len_clamp = (load_len > ADDR_W'(DEPTH)) ? ADDR_W'(DEPTH) : load_len;
  assign idle      = (state_q == ST_IDLE);
  assign load_go   = idle && load_start && (len_clamp != '0);
  assign load_zero = idle && load_start && (len_clamp == '0);
  assign rd_go     = idle && !load_start && rd_start && (rd_count != '0);
  assign rd_zero   = idle && !load_start && rd_start && (rd_count == '0);
  assign in_xfer   = (state_q == ST_LOAD) && bus.in_valid;
  assign load_end  = in_xfer && (cnt_q == ADDR_W'(1));
  // Only issue when the output register will be free at the capturing edge
  assign issue     = (state_q == ST_READ) && ag_active && (!out_valid_q || bus.out_ready);
  assign rd_hs     = out_valid_q && bus.out_ready;
  assign rd_last   = rd_hs && final_q;

  filter_addr_gen #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_addr_gen (
    .clk    (clk),
    .reset  (reset),
    .start  (rd_go),
    .base   (rd_base),
    .stride (rd_stride),
    .count  (rd_count),
    .step   (issue),
    .addr   (ag_addr),
    .active (ag_active),
    .last   (ag_last)
  );

  always_comb begin
    state_d      = state_q;
    bus.in_ready = 1'b0;
    busy         = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (load_go)    state_d = ST_LOAD;
        else if (rd_go) state_d = ST_READ;
      end
      ST_LOAD: begin
        bus.in_ready = 1'b1;
        if (load_end) state_d = ST_IDLE;
      end
      ST_READ: begin
        if (rd_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      load_done_q <= 1'b0;
      zero_rd_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      final_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_done_q <= load_zero || load_end;
      zero_rd_q   <= rd_zero;
      we_q        <= in_xfer;
      if (load_go) begin
        cnt_q <= len_clamp;
        ptr_q <= '0;
      end else if (in_xfer) begin
        addr_q  <= ptr_q;
        wdata_q <= bus.in_data;
        ptr_q   <= ptr_q + 1'b1;
        cnt_q   <= cnt_q - 1'b1;
      end
      if (issue) begin
        out_valid_q <= 1'b1;
        out_data_q  <= bus.spad_rdata;
      end else if (rd_hs) begin
        out_valid_q <= 1'b0;
      end
      if (rd_go || rd_last)      final_q <= 1'b0;
      else if (issue && ag_last) final_q <= 1'b1;
    end
  end

`ifdef FILTER_SPAD_CTRL_CHECKSUM_EN
  logic [DATA_W-1:0] chk_q;
  always_ff @(posedge clk) begin
    if (reset || (idle && load_start)) chk_q <= '0;
    else if (in_xfer)                  chk_q <= chk_q ^ bus.in_data;
  end
  assign load_chk = chk_q;
`endif

  // Read address comes straight from the walker so a read costs no extra cycle
  assign bus.spad_addr  = (state_q == ST_READ) ? ag_addr : addr_q;
  assign bus.spad_we    = we_q && !reset;
  assign bus.spad_wdata = wdata_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign load_done      = load_done_q;
  assign rd_done        = zero_rd_q || rd_last;
endmodule

// File: tb/tb_filter_spad_ctrl.sv
// Directed and randomized bench for filter_spad_ctrl against a negedge spad model and a reference memory.
module tb_filter_spad_ctrl;
  localparam int DEPTH = 224;

  logic        clk, reset;
  logic        load_start, load_done, rd_start, rd_done, busy;
  logic [7:0]  load_len, rd_base, rd_count, rd_stride;
  logic [15:0] load_chk;

  filter_spad_ctrl_if bus ();

  filter_spad_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_len   (load_len),
    .load_done  (load_done),
    .rd_start   (rd_start),
    .rd_base    (rd_base),
    .rd_count   (rd_count),
    .rd_stride  (rd_stride),
    .rd_done    (rd_done),
    .busy       (busy),
`ifdef FILTER_SPAD_CTRL_CHECKSUM_EN
    .load_chk   (load_chk),
`endif
    .bus        (bus)
  );

`ifndef FILTER_SPAD_CTRL_CHECKSUM_EN
  assign load_chk = 16'h0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Spad model: writes and reads land on the falling edge
  logic [15:0] spad_mem [0:DEPTH-1];
  int bad_wr = 0;
  always @(negedge clk) begin
    if (bus.spad_we) begin
      if (int'(bus.spad_addr) < DEPTH) spad_mem[bus.spad_addr] <= bus.spad_wdata;
      else bad_wr++;
    end
    bus.spad_rdata <= (int'(bus.spad_addr) < DEPTH) ? spad_mem[bus.spad_addr] : 16'hxxxx;
  end

  // Monitor: everything here only grows; the stimulus takes snapshots
  logic [7:0]  wr_a [$];
  logic [15:0] wr_d [$];
  logic [15:0] rd_q [$];
  int ld_done_cnt = 0, ld_done_cyc = 0, rd_done_cnt = 0, rd_done_cyc = 0, last_hs_cyc = 0;
  int busy_cnt = 0, valid_cnt = 0, unstable = 0;
  logic        ld_done_we;
  logic [7:0]  ld_done_addr;
  logic [15:0] chk_at_done, stall_data;
  logic        stall_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.spad_we) begin
      wr_a.push_back(bus.spad_addr);
      wr_d.push_back(bus.spad_wdata);
    end
    if (load_done) begin
      ld_done_cnt++;
      ld_done_cyc  = cyc;
      ld_done_we   = bus.spad_we;
      ld_done_addr = bus.spad_addr;
      chk_at_done  = load_chk;
    end
    if (bus.out_valid && bus.out_ready) begin
      rd_q.push_back(bus.out_data);
      last_hs_cyc = cyc;
    end
    if (rd_done) begin
      rd_done_cnt++;
      rd_done_cyc = cyc;
    end
    if (busy) busy_cnt++;
    if (bus.out_valid) valid_cnt++;
    if (stall_prev && bus.out_data !== stall_data) unstable++;
    stall_prev = bus.out_valid && !bus.out_ready;
    stall_data = bus.out_data;
  end

  logic [15:0] ld_words [0:255];
  logic [15:0] ref_mem [0:DEPTH-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_load(input int len, input int mode, input bit with_rd);
    int n, idx, k, st, d0, w0, mism, r0;
    logic [15:0] x;
    n = (len > DEPTH) ? DEPTH : len;
    d0 = ld_done_cnt; w0 = wr_a.size(); r0 = rd_done_cnt;
    @(posedge clk); #1;
    load_start = 1'b1; load_len = 8'(len); st = cyc;
    if (with_rd) begin
      rd_start = 1'b1; rd_base = 8'd0; rd_count = 8'd3; rd_stride = 8'd1;
    end
    idx = 0; k = 0;
    while (ld_done_cnt == d0 && k < 3000) begin
      @(posedge clk); #1;
      load_start = 1'b0; rd_start = 1'b0;
      if (k == 0 && n > 0) check("in_ready_after_start", bus.in_ready, 1'b1);
      bus.in_valid = (idx < n) && (mode == 0 || $urandom_range(0, 2) != 0);
      bus.in_data  = ld_words[idx];
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) idx++;
      k++;
    end
    #1 bus.in_valid = 1'b0;
    idle_cycles(2);
    check("load_timeout", k < 3000, 1'b1);
    check("load_done_once", ld_done_cnt - d0, 1);
    check("load_write_count", wr_a.size() - w0, n);
    mism = 0; x = '0;
    for (int i = 0; i < n && (w0 + i) < wr_a.size(); i++) begin
      if (wr_a[w0+i] !== 8'(i) || wr_d[w0+i] !== ld_words[i]) mism++;
      x ^= ld_words[i];
      ref_mem[i] = ld_words[i];
    end
    check("load_write_seq", mism, 0);
    mism = 0;
    for (int i = 0; i < n; i++) if (spad_mem[i] !== ld_words[i]) mism++;
    check("spad_contents", mism, 0);
    if (n == 0) check("zero_load_latency", ld_done_cyc - st, 1);
    else check("load_done_with_last_write", {ld_done_we, ld_done_addr}, {1'b1, 8'(n - 1)});
    if (mode == 0) check("load_latency", ld_done_cyc - st, n + 1);
    if (with_rd) check("collision_no_rd_done", rd_done_cnt - r0, 0);
`ifdef FILTER_SPAD_CTRL_CHECKSUM_EN
    if (n > 0) check("load_chk", chk_at_done, x);
`endif
  endtask

  task automatic run_read(input int base, input int cnt, input int stride, input int mode);
    int k, st, d0, r0, mism, a;
    logic [15:0] exp_q [$];
    d0 = rd_done_cnt; r0 = rd_q.size();
    for (int i = 0; i < cnt; i++) begin
      a = (base + i * stride) % DEPTH;
      exp_q.push_back(ref_mem[a]);
    end
    @(posedge clk); #1;
    rd_start = 1'b1; rd_base = 8'(base); rd_count = 8'(cnt); rd_stride = 8'(stride);
    bus.out_ready = 1'b1; st = cyc; k = 0;
    while (rd_done_cnt == d0 && k < 3000) begin
      @(posedge clk); #1;
      rd_start = 1'b0;
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 2) != 0);
        default: bus.out_ready = (k == 1 || k == 2) ? 1'b0 : 1'b1;
      endcase
      k++;
      @(negedge clk);
    end
    #1 bus.out_ready = 1'b1;
    idle_cycles(2);
    check("read_timeout", k < 3000, 1'b1);
    check("rd_done_once", rd_done_cnt - d0, 1);
    check("read_word_count", rd_q.size() - r0, cnt);
    mism = 0;
    for (int i = 0; i < cnt && (r0 + i) < rd_q.size(); i++) if (rd_q[r0+i] !== exp_q[i]) mism++;
    check("read_words", mism, 0);
    if (cnt == 0) check("zero_read_latency", rd_done_cyc - st, 1);
    else check("rd_done_on_last_accept", rd_done_cyc, last_hs_cyc);
    if (mode == 0) check("read_latency", rd_done_cyc - st, cnt + 1);
  endtask

  initial begin
    int b0, v0, w0;
    reset = 1'b1; load_start = 1'b0; load_len = '0; rd_start = 1'b0;
    rd_base = '0; rd_count = '0; rd_stride = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    idle_cycles(3);
    reset = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, 16'h0);
    check("rst_spad_we", bus.spad_we, 1'b0);
    check("rst_spad_addr", bus.spad_addr, 8'h0);
    check("rst_spad_wdata", bus.spad_wdata, 16'h0);
    check("rst_load_done", load_done, 1'b0);
    check("rst_rd_done", rd_done, 1'b0);

    // Full-throughput four-word load
    ld_words[0] = 16'h1111; ld_words[1] = 16'h2222; ld_words[2] = 16'h3333; ld_words[3] = 16'h4444;
    run_load(4, 0, 1'b0);

    // Reset for one cycle in the middle of a load
    w0 = wr_a.size();
    @(posedge clk); #1 load_start = 1'b1; load_len = 8'd10;
    @(posedge clk); #1 load_start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'hAAAA;
    @(posedge clk); #1 bus.in_data = 16'hBBBB;
    @(posedge clk); #1 bus.in_data = 16'hCCCC;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("midrst_no_we_in_reset", bus.spad_we, 1'b0);
    @(posedge clk); #1 reset = 1'b0; bus.in_valid = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_in_ready", bus.in_ready, 1'b0);
    check("midrst_outputs", {bus.spad_we, bus.spad_addr, bus.spad_wdata, bus.out_valid, bus.out_data,
                             load_done, rd_done}, '0);
    check("midrst_writes", wr_a.size() - w0, 2);

    // Clamped load fills the whole spad with random words
    for (int i = 0; i < 256; i++) ld_words[i] = 16'($urandom);
    run_load(250, 1, 1'b0);
    check("no_out_of_range_write", bad_wr, 0);

    run_read(220, 4, 3, 0);
    b0 = unstable;
    run_read(10, 3, 1, 2);
    check("stall_stable", unstable - b0, 0);

    // Zero-length read and load
    b0 = busy_cnt; v0 = valid_cnt;
    run_read(5, 0, 1, 0);
    check("zero_read_not_busy", busy_cnt - b0, 0);
    check("zero_read_no_valid", valid_cnt - v0, 0);
    run_load(0, 0, 1'b0);

    // Collision: load wins, read ignored
    v0 = valid_cnt;
    for (int i = 0; i < 5; i++) ld_words[i] = 16'h5000 + 16'(i);
    run_load(5, 0, 1'b1);
    check("collision_no_read", valid_cnt - v0, 0);

    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 256; i++) ld_words[i] = 16'($urandom);
      run_load($urandom_range(1, 230), 1, 1'b0);
      run_read($urandom_range(0, DEPTH - 1), $urandom_range(1, 30), $urandom_range(0, DEPTH - 1), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
